// File: rtl/pkt_len_stamp.sv
// pkt_len_stamp: store-and-forward AXI-Stream stage that counts the bytes of
// each packet and stamps that count into tuser[15:0] of the packet's first
// output beat. Packets are written into a beat buffer and are not released
// until their tlast beat has been received. The length queue holds one entry
// per complete packet.
//
// Optional feature macro: PKT_LEN_STAMP_RUNT_DROP_EN
//   defined   -> packets with a byte count below 60 are discarded at tlast
//   undefined -> every packet is forwarded and stamped
module pkt_len_stamp #(
    parameter int C_AXIS_DATA_WIDTH  = 512,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int DATA_DEPTH         = 256,
    parameter int LEN_DEPTH          = 16
) (
    input  logic                            clk,
    input  logic                            reset,

    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                            s_axis_tlast,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,

    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tlast,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready
);

    localparam int KW = C_AXIS_DATA_WIDTH / 8;
    localparam int AW = $clog2(DATA_DEPTH);
    localparam int LW = $clog2(LEN_DEPTH);

    localparam logic [AW:0] BUF_FULL = (AW+1)'(DATA_DEPTH);
    localparam logic [LW:0] LQ_FULL  = (LW+1)'(LEN_DEPTH);
    localparam logic [AW:0] BUF_ONE  = (AW+1)'(1);
    localparam logic [LW:0] LQ_ONE   = (LW+1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        BODY
    } rd_state_e;

    // Beat buffer and length queue storage.
    logic [C_AXIS_DATA_WIDTH-1:0]  data_mem [DATA_DEPTH];
    logic [KW-1:0]                 keep_mem [DATA_DEPTH];
    logic [C_AXIS_TUSER_WIDTH-1:0] user_mem [DATA_DEPTH];
    logic                          last_mem [DATA_DEPTH];
    logic [15:0]                   len_mem  [LEN_DEPTH];

    // Pointers carry one extra bit so full and empty can be told apart.
    logic [AW:0]  wr_spec_q, wr_spec_d;   // next free beat, includes the open packet
    logic [AW:0]  wr_com_q,  wr_com_d;    // end of the last complete packet
    logic [AW:0]  rd_q,      rd_d;
    logic [LW:0]  lq_wr_q,   lq_wr_d;
    logic [LW:0]  lq_rd_q,   lq_rd_d;
    logic [15:0]  acc_q,     acc_d;
    rd_state_e    state_q,   state_d;

    logic         s_hs;
    logic         lq_push;
    logic         is_runt;
    logic [15:0]  pkt_bytes;
    logic [AW:0]  buf_used;
    logic [LW:0]  lq_used;
    logic         m_valid;
    logic         m_hs;
    logic         rd_last;
    logic [AW-1:0] rd_addr;
    logic [C_AXIS_TUSER_WIDTH-1:0] user_out;

    // Number of asserted tkeep bits; tkeep may have holes.
    function automatic logic [15:0] popcount(input logic [KW-1:0] keep);
        logic [15:0] n;
        n = '0;
        for (int i = 0; i < KW; i++) begin
            n = n + 16'(keep[i]);
        end
        return n;
    endfunction

    // Write side: backpressure, byte accumulation and packet commit/drop.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        wr_spec_d = wr_spec_q;
        wr_com_d  = wr_com_q;
        acc_d     = acc_q;
        lq_wr_d   = lq_wr_q;
        lq_push   = 1'b0;

        buf_used  = wr_spec_q - rd_q;
        lq_used   = lq_wr_q - lq_rd_q;

        // Held low throughout reset; opens on the first cycle after it.
        s_axis_tready = !reset && (buf_used != BUF_FULL) && (lq_used != LQ_FULL);
        s_hs          = s_axis_tvalid && s_axis_tready;
        pkt_bytes     = acc_q + popcount(s_axis_tkeep);

`ifdef PKT_LEN_STAMP_RUNT_DROP_EN
        is_runt = (pkt_bytes < 16'd60);
`else
        is_runt = 1'b0;
`endif

        if (s_hs) begin
            if (s_axis_tlast) begin
                acc_d = '0;
                if (is_runt) begin
                    // Forget every beat of this packet, including the one just offered.
                    wr_spec_d = wr_com_q;
                end else begin
                    wr_spec_d = wr_spec_q + BUF_ONE;
                    wr_com_d  = wr_spec_q + BUF_ONE;
                    lq_wr_d   = lq_wr_q + LQ_ONE;
                    lq_push   = 1'b1;
                end
            end else begin
                wr_spec_d = wr_spec_q + BUF_ONE;
                acc_d     = pkt_bytes;
            end
        end
    end

    // Read side: IDLE/FIRST/BODY sequencing and output beat formation.
    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        lq_rd_d = lq_rd_q;

        rd_addr = rd_q[AW-1:0];
        rd_last = last_mem[rd_addr];
        m_valid = (state_q != IDLE) && !reset;
        m_hs    = m_valid && m_axis_tready;

        user_out = user_mem[rd_addr];
        if (state_q == FIRST) begin
            user_out[15:0] = len_mem[lq_rd_q[LW-1:0]];
        end

        case (state_q)
            IDLE: begin
                if (lq_used != '0) begin
                    state_d = FIRST;
                end
            end
            FIRST, BODY: begin
                if (m_hs) begin
                    rd_d = rd_q + BUF_ONE;
                    if (rd_last) begin
                        lq_rd_d = lq_rd_q + LQ_ONE;
                        // Another complete packet waiting: start it with no idle cycle.
                        state_d = (lq_used > LQ_ONE) ? FIRST : IDLE;
                    end else begin
                        state_d = BODY;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Payload is forced to zero whenever no beat is presented.
        m_axis_tvalid = m_valid;
        m_axis_tdata  = m_valid ? data_mem[rd_addr] : '0;
        m_axis_tkeep  = m_valid ? keep_mem[rd_addr] : '0;
        m_axis_tuser  = m_valid ? user_out          : '0;
        m_axis_tlast  = m_valid && rd_last;
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            wr_spec_q <= '0;
            wr_com_q  <= '0;
            rd_q      <= '0;
            lq_wr_q   <= '0;
            lq_rd_q   <= '0;
            acc_q     <= '0;
            state_q   <= IDLE;
        end else begin
            wr_spec_q <= wr_spec_d;
            wr_com_q  <= wr_com_d;
            rd_q      <= rd_d;
            lq_wr_q   <= lq_wr_d;
            lq_rd_q   <= lq_rd_d;
            acc_q     <= acc_d;
            state_q   <= state_d;
        end
    end

    // Storage writes: beat buffer on every accepted beat, length queue on commit.
    always_ff @(posedge clk) begin
        // NOTE: storage arrays are not reset; the cleared pointers mark every entry invalid.
        if (s_hs) begin
            data_mem[wr_spec_q[AW-1:0]] <= s_axis_tdata;
            keep_mem[wr_spec_q[AW-1:0]] <= s_axis_tkeep;
            user_mem[wr_spec_q[AW-1:0]] <= s_axis_tuser;
            last_mem[wr_spec_q[AW-1:0]] <= s_axis_tlast;
        end
        if (lq_push) begin
            len_mem[lq_wr_q[LW-1:0]] <= pkt_bytes;
        end
    end

endmodule

// File: tb/tb_pkt_len_stamp.sv
// Testbench for pkt_len_stamp. A packet-level reference model turns every
// accepted input packet into its expected output beats (byte count from the
// tkeep population, first-beat tuser[15:0] replaced by it, runts removed when
// PKT_LEN_STAMP_RUNT_DROP_EN is defined) and each accepted output beat is
// compared against the head of that expectation queue.
module tb_pkt_len_stamp;

    localparam int W  = 512;
    localparam int KW = W / 8;
    localparam int U  = 128;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  s_tdata;
    logic [KW-1:0] s_tkeep;
    logic [U-1:0]  s_tuser;
    logic          s_tlast;
    logic          s_tvalid;
    logic          s_tready;
    logic [W-1:0]  m_tdata;
    logic [KW-1:0] m_tkeep;
    logic [U-1:0]  m_tuser;
    logic          m_tlast;
    logic          m_tvalid;
    logic          m_tready;

    always #5 clk = ~clk;

    pkt_len_stamp #(
        .C_AXIS_DATA_WIDTH  (W),
        .C_AXIS_TUSER_WIDTH (U),
        .DATA_DEPTH         (256),
        .LEN_DEPTH          (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tuser  (s_tuser),
        .s_axis_tlast  (s_tlast),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tuser  (m_tuser),
        .m_axis_tlast  (m_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready)
    );

    typedef struct {
        logic [W-1:0]  d;
        logic [KW-1:0] k;
        logic [U-1:0]  u;
        logic          l;
    } beat_t;

    beat_t cur_pkt[$];
    beat_t exp_q[$];
    beat_t prev_beat;
    bit    prev_stall = 1'b0;
    bit    last_s_hs  = 1'b0;
    int    ready_mode = 0;   // 0 always ready, 1 never, 2 random, 3 toggle
    int    out_pkts   = 0;
    int    pass_cnt   = 0;
    int    fail_cnt   = 0;
    int    chk_cnt    = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_data();
        logic [W-1:0] d;
        for (int i = 0; i < W / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [U-1:0] rand_user();
        logic [U-1:0] u;
        for (int i = 0; i < U / 32; i++) u[i*32 +: 32] = $urandom;
        return u;
    endfunction

    // Reference model: a complete input packet becomes expected output beats.
    task automatic model_in();
        beat_t b;
        int    bytes;
        bit    drop;
        b.d = s_tdata; b.k = s_tkeep; b.u = s_tuser; b.l = s_tlast;
        cur_pkt.push_back(b);
        if (s_tlast) begin
            bytes = 0;
            foreach (cur_pkt[i]) bytes += $countones(cur_pkt[i].k);
`ifdef PKT_LEN_STAMP_RUNT_DROP_EN
            drop = (bytes < 60);
`else
            drop = 1'b0;
`endif
            if (!drop) begin
                b = cur_pkt[0];
                b.u[15:0] = 16'(bytes);
                cur_pkt[0] = b;
                foreach (cur_pkt[i]) exp_q.push_back(cur_pkt[i]);
            end
            cur_pkt.delete();
        end
    endtask

    task automatic check_out();
        beat_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_beat", W'(m_tvalid), '0);
        end else begin
            e = exp_q.pop_front();
            chk("out_tdata", m_tdata, e.d);
            chk("out_tkeep", W'(m_tkeep), W'(e.k));
            chk("out_tuser", W'(m_tuser), W'(e.u));
            chk("out_tlast", W'(m_tlast), W'(e.l));
            if (e.l) out_pkts++;
        end
    endtask

    // One clock cycle: set ready, sample handshakes just after the falling edge.
    task automatic step();
        case (ready_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = 1'b0;
            2:       m_tready = 1'($urandom_range(0, 1));
            default: m_tready = ~m_tready;
        endcase
        #1;
        if (prev_stall) begin
            chk("stall_valid", W'(m_tvalid), W'(1));
            chk("stall_tdata", m_tdata, prev_beat.d);
            chk("stall_tuser", W'(m_tuser), W'(prev_beat.u));
            chk("stall_tkeep", W'(m_tkeep), W'(prev_beat.k));
        end
        last_s_hs = s_tvalid && s_tready;
        if (last_s_hs) model_in();
        if (m_tvalid && m_tready) check_out();
        prev_stall  = m_tvalid && !m_tready;
        prev_beat.d = m_tdata;
        prev_beat.k = m_tkeep;
        prev_beat.u = m_tuser;
        prev_beat.l = m_tlast;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_beat(input logic [KW-1:0] keep, input bit last);
        int n;
        n        = 0;
        s_tdata  = rand_data();
        s_tuser  = rand_user();
        s_tkeep  = keep;
        s_tlast  = last;
        s_tvalid = 1'b1;
        do begin
            step();
            n++;
        end while (!last_s_hs && n < 500);
        if (!last_s_hs) chk("send_timeout", W'(last_s_hs), W'(1));
        s_tvalid = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        ready_mode = (ready_mode == 3) ? 3 : 0;
        while ((exp_q.size() != 0 || m_tvalid) && n < max_cycles) begin
            step();
            n++;
        end
        chk("drain_empty", W'(exp_q.size()), '0);
    endtask

    task automatic do_reset(input int cycles);
        reset    = 1'b1;
        s_tvalid = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            #1;
            chk("rst_s_tready", W'(s_tready), '0);
            chk("rst_m_tvalid", W'(m_tvalid), '0);
            chk("rst_m_tdata",  m_tdata, '0);
            chk("rst_m_tuser",  W'(m_tuser), '0);
            @(posedge clk);
            @(negedge clk);
        end
        reset      = 1'b0;
        prev_stall = 1'b0;
        cur_pkt.delete();
        exp_q.delete();
        #1;
        chk("ready_after_reset", W'(s_tready), W'(1));
    endtask

    initial begin
        logic [KW-1:0] ones;
        logic [KW-1:0] keep42;
        logic [KW-1:0] floor60;
        int            base;
        int            lens[3];

        ones    = '1;
        keep42  = (KW'(1) << 42) - KW'(1);
        floor60 = (KW'(1) << 60) - KW'(1);
        lens    = '{1, 3, 2};

        reset    = 1'b1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tkeep  = '0;
        s_tdata  = '0;
        s_tuser  = '0;
        m_tready = 1'b0;
        @(negedge clk);
        do_reset(3);

        // Two-beat 68-byte packet: stamp and store-and-forward latency.
        ready_mode = 0;
        base = out_pkts;
        send_beat(ones, 1'b0);
        send_beat(KW'(64'hF), 1'b1);
        #1;
        chk("lat_not_early", W'(m_tvalid), '0);
        step();
        #1;
        chk("lat_valid_at_2", W'(m_tvalid), W'(1));
        drain(50);
        chk("single_pkt_count", W'(out_pkts - base), W'(1));

        // Back-to-back 1/3/2-beat packets drained with ready held high.
        ready_mode = 1;
        foreach (lens[p])
            for (int b = 0; b < lens[p]; b++)
                send_beat(KW'({$urandom, $urandom}) | floor60, b == lens[p] - 1);
        step();
        step();
        ready_mode = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("no_bubble", W'(m_tvalid), W'(1));
            step();
        end
        drain(20);

        // Same shape drained with ready toggling; payload must hold while stalled.
        ready_mode = 1;
        base = out_pkts;
        foreach (lens[p])
            for (int b = 0; b < lens[p]; b++)
                send_beat(KW'({$urandom, $urandom}) | floor60, b == lens[p] - 1);
        ready_mode = 3;
        drain(100);
        chk("toggle_pkt_count", W'(out_pkts - base), W'(3));

        // Sixteen one-beat packets with the output stalled fill the length queue.
        ready_mode = 1;
        base = out_pkts;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                #1;
                chk("ready_before_16th", W'(s_tready), W'(1));
            end
            send_beat(ones, 1'b1);
        end
        step();
        #1;
        chk("lenq_full_backpressure", W'(s_tready), '0);
        ready_mode = 0;
        drain(200);
        chk("lenq_drain_count", W'(out_pkts - base), W'(16));

        // Runt (42 bytes) followed by a 64-byte packet.
        ready_mode = 0;
        base = out_pkts;
        send_beat(keep42, 1'b1);
        send_beat(ones, 1'b1);
        drain(50);
`ifdef PKT_LEN_STAMP_RUNT_DROP_EN
        chk("runt_pkt_count", W'(out_pkts - base), W'(1));
`else
        chk("runt_pkt_count", W'(out_pkts - base), W'(2));
`endif

        // Reset on the second beat of a four-beat packet discards it.
        ready_mode = 0;
        send_beat(ones, 1'b0);
        s_tdata  = rand_data();
        s_tkeep  = ones;
        s_tlast  = 1'b0;
        s_tvalid = 1'b1;
        do_reset(2);
        s_tvalid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        base = out_pkts;
        send_beat(ones, 1'b1);
        drain(50);
        chk("post_reset_pkt_count", W'(out_pkts - base), W'(1));

        // Randomized traffic: lengths 1..6, sparse tkeep, random gaps and ready.
        ready_mode = 2;
        for (int p = 0; p < 40; p++) begin
            int nb;
            nb = $urandom_range(1, 6);
            for (int b = 0; b < nb; b++) begin
                send_beat(KW'({$urandom, $urandom}), b == nb - 1);
                if ($urandom_range(0, 3) == 0) step();
            end
        end
        ready_mode = 0;
        drain(2000);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
